// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Opcode constants, default width and helpers shared by the ALU command issuer.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'b000;
  localparam alu_op_t OP_SUB = 3'b001;
  localparam alu_op_t OP_AND = 3'b010;
  localparam alu_op_t OP_OR  = 3'b011;
  localparam alu_op_t OP_XOR = 3'b100;
  localparam alu_op_t OP_NOT = 3'b101;

  function automatic logic op_is_arith(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - Combinational golden model of the 4-bit ALU used for on-line self-checking.
module alu_ref_model import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          sel,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] wide;

  // Top bit of the widened difference is the borrow for SUB.
  always_comb begin
    wide = '0;
    case (sel)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOT:  wide = {1'b0, ~a};
      default: wide = '0;
    endcase
    result = wide[WIDTH-1:0];
    carry  = wide[WIDTH];
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - Issues commands to the combinational ALU and returns captured results.
// Optional self-check against alu_ref_model under ALU_CMD_ISSUER_SELF_CHECK_EN.
module alu_cmd_issuer import alu_pkg::*; #(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept, capture, rsp_hs;

  // Reset gating keeps the handshake outputs quiet for the whole reset pulse.
  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign rsp_valid = (state == RESP) && !rst;

  assign accept  = cmd_valid && cmd_ready;
  assign capture = (state == WAIT) && (settle_cnt == 4'd1);
  assign rsp_hs  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (settle_cnt == 4'd1) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      settle_cnt <= '0;
      rsp_op     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      done_count <= '0;
    end else begin
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_sel    <= cmd_op;
        settle_cnt <= 4'(SETTLE);
      end else if (state == WAIT) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      // Logic ops leave the ALU carry undefined, so it is masked here.
      if (capture) begin
        rsp_op     <= alu_sel;
        rsp_result <= alu_result;
        rsp_carry  <= op_is_arith(alu_sel) && alu_carry;
      end
      if (rsp_hs) done_count <= done_count + CNT_W'(1);
    end
  end

`ifdef ALU_CMD_ISSUER_SELF_CHECK_EN
  logic [WIDTH-1:0] ref_result;
  logic             ref_carry;
  logic             mismatch;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref_model (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (ref_result),
    .carry  (ref_carry)
  );

  assign mismatch = (ref_result != alu_result) ||
                    (op_is_arith(alu_sel) && (ref_carry != alu_carry));

  always_ff @(posedge clk) begin
    if (rst)                      err <= 1'b0;
    else if (capture && mismatch) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
